dram_cmd_responder: RTL and testbench



---
 rtl/dram_cmd_responder_pkg.sv | 63 ++++++
 rtl/dram_cmd_responder_if.sv | 20 ++
 rtl/dram_cmd_responder_array.sv | 25 ++
 rtl/dram_cmd_responder.sv | 148 ++++++++++++++
 tb/tb_dram_cmd_responder.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_cmd_responder_pkg.sv
// Shared types, default timing and helpers for the DRAM command responder.
// Optional write-to-read forwarding is enabled by DRAM_RESP_WRBYPASS_EN.
package dram_pkg;

  localparam int DEF_ROW_BITS = 11;
  localparam int DEF_COL_BITS = 10;
  localparam int DEF_T_RP     = 5;
  localparam int DEF_T_RCD    = 5;
  localparam int DEF_T_CL     = 5;

  localparam logic [3:0] WEN_ALL_OFF = 4'hF;
  localparam logic [3:0] WEN_PRE     = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECHG,
    ST_ACTIVATING,
    ST_ROW_OPEN,
    ST_READ_LAT
  } state_e;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_PRE,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_ILL
  } cmd_e;

  function automatic cmd_e decode_cmd(input logic csn, input logic rasn,
                                      input logic casn, input logic [3:0] wen);
    cmd_e c;
    c = CMD_ILL;
    if (csn || (rasn && casn))          c = CMD_NOP;
    else if (!rasn && casn) begin
      if (wen == WEN_PRE)               c = CMD_PRE;
      else if (wen == WEN_ALL_OFF)      c = CMD_ACT;
    end else if (rasn && !casn) begin
      if (wen == WEN_ALL_OFF)           c = CMD_RD;
      else                              c = CMD_WR;
    end
    return c;
  endfunction

  // WEn is active-low: a 0 bit takes that byte from the incoming data.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] wr_w,
                                             input logic [3:0] wen);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (!wen[i]) r[8*i +: 8] = wr_w[8*i +: 8];
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dram_cmd_responder_if.sv
// DRAM pin bundle between the AXI-side controller (master) and the device model (slave).
interface dram_cmd_responder_if;

  logic        CSn;
  logic        RASn;
  logic        CASn;
  logic [3:0]  WEn;
  logic [10:0] A;
  logic [31:0] D;
  logic [31:0] Q;
  logic        valid;
  logic        cmd_err;

  modport master (output CSn, RASn, CASn, WEn, A, D,
                  input  Q, valid, cmd_err);

  modport slave  (input  CSn, RASn, CASn, WEn, A, D,
                  output Q, valid, cmd_err);

endinterface

// File: rtl/dram_cmd_responder_array.sv
// Byte-enabled 32-bit storage with one write port and one registered read port.
// Contents are intentionally not reset so data survives a controller reset.
module dram_array #(
  parameter int AW = 21
) (
  input  logic          ACLK,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_be,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [0:(2**AW)-1];

  always_ff @(posedge ACLK) begin
    if (wr_en)
      for (int i = 0; i < 4; i++)
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dram_cmd_responder.sv
// Single-bank DRAM device model: decodes PRE/ACT/RD/WR, enforces tRP/tRCD/tCL, flags misuse.
// Define DRAM_RESP_WRBYPASS_EN to forward a same-address WRITE into Q on the read-expiry cycle.
//
// state         | meaning
// ST_IDLE       | no open row; ACT or PRE accepted
// ST_PRECHG     | tRP running; returns to idle on the terminal count
// ST_ACTIVATING | tRCD running; row becomes usable on the terminal count
// ST_ROW_OPEN   | row latched; RD, WR, PRE accepted
// ST_READ_LAT   | tCL running; Q/valid updated on the terminal count
module dram_cmd_responder
  import dram_pkg::*;
#(
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int T_RP     = DEF_T_RP,
  parameter int T_RCD    = DEF_T_RCD,
  parameter int T_CL     = DEF_T_CL
) (
  input logic                  ACLK,
  input logic                  ARESET,
  dram_cmd_responder_if.slave  dram
);

  localparam int AW    = ROW_BITS + COL_BITS;
  localparam int CNT_W = $clog2(max3(T_RP, T_RCD, T_CL)) + 1;

  state_e                state;
  state_e                eff_state;
  cmd_e                  cmd;
  logic [CNT_W-1:0]      cnt;
  logic [ROW_BITS-1:0]   row_q;
  logic [31:0]           q_q;
  logic                  valid_q;
  logic                  err_q;
  logic                  cnt_done;
  logic                  cmd_bad;
  logic                  wr_en;
  logic                  rd_en;
  logic                  byp_hit;
  logic [AW-1:0]         acc_addr;
  logic [31:0]           rd_data;

`ifdef DRAM_RESP_WRBYPASS_EN
  logic [COL_BITS-1:0]   rd_col_q;
`endif

  // The terminal-count edge of tRP/tRCD already behaves like the following state.
  always_comb begin
    cmd       = decode_cmd(dram.CSn, dram.RASn, dram.CASn, dram.WEn);
    cnt_done  = (cnt == '0);
    eff_state = state;
    if (state == ST_PRECHG && cnt_done)     eff_state = ST_IDLE;
    if (state == ST_ACTIVATING && cnt_done) eff_state = ST_ROW_OPEN;
    cmd_bad = 1'b0;
    case (cmd)
      CMD_NOP: cmd_bad = 1'b0;
      CMD_PRE: cmd_bad = !(eff_state == ST_IDLE || eff_state == ST_ROW_OPEN);
      CMD_ACT: cmd_bad = (eff_state != ST_IDLE);
      CMD_RD:  cmd_bad = (eff_state != ST_ROW_OPEN);
`ifdef DRAM_RESP_WRBYPASS_EN
      CMD_WR:  cmd_bad = !(eff_state == ST_ROW_OPEN ||
                           (state == ST_READ_LAT && cnt_done));
`else
      CMD_WR:  cmd_bad = (eff_state != ST_ROW_OPEN);
`endif
      default: cmd_bad = 1'b1;
    endcase
  end

  assign acc_addr = {row_q, dram.A[COL_BITS-1:0]};
  assign wr_en    = (cmd == CMD_WR) && !cmd_bad;
  assign rd_en    = (cmd == CMD_RD) && !cmd_bad;

`ifdef DRAM_RESP_WRBYPASS_EN
  assign byp_hit = wr_en && (state == ST_READ_LAT) && (dram.A[COL_BITS-1:0] == rd_col_q);
`else
  assign byp_hit = 1'b0;
`endif

  // Array is read at the READ edge; nothing may write it until tCL expires.
  dram_array #(.AW(AW)) u_array (
    .ACLK    (ACLK),
    .wr_en   (wr_en),
    .wr_addr (acc_addr),
    .wr_data (dram.D),
    .wr_be   (~dram.WEn),
    .rd_en   (rd_en),
    .rd_addr (acc_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      row_q   <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef DRAM_RESP_WRBYPASS_EN
      rd_col_q <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (cmd_bad)   err_q <= 1'b1;
      if (!cnt_done) cnt   <= cnt - CNT_W'(1);

      case (state)
        ST_PRECHG:     if (cnt_done) state <= ST_IDLE;
        ST_ACTIVATING: if (cnt_done) state <= ST_ROW_OPEN;
        ST_READ_LAT:
          if (cnt_done) begin
            state   <= ST_ROW_OPEN;
            valid_q <= 1'b1;
            q_q     <= byp_hit ? byte_merge(rd_data, dram.D, dram.WEn) : rd_data;
          end
        default: ;
      endcase

      if (!cmd_bad) begin
        case (cmd)
          CMD_PRE: begin
            state <= ST_PRECHG;
            cnt   <= CNT_W'(T_RP - 1);
          end
          CMD_ACT: begin
            state <= ST_ACTIVATING;
            cnt   <= CNT_W'(T_RCD - 1);
            row_q <= dram.A[ROW_BITS-1:0];
          end
          CMD_RD: begin
            state <= ST_READ_LAT;
            cnt   <= CNT_W'(T_CL - 1);
`ifdef DRAM_RESP_WRBYPASS_EN
            rd_col_q <= dram.A[COL_BITS-1:0];
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign dram.Q       = q_q;
  assign dram.valid   = valid_q;
  assign dram.cmd_err = err_q;

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Directed and randomized bench for dram_cmd_responder against a timestamp-based device model.
module tb_dram_cmd_responder;

  localparam int T_RP     = 5;
  localparam int T_RCD    = 5;
  localparam int T_CL     = 5;
  localparam int COL_BITS = 10;

  logic ACLK = 1'b0;
  logic ARESET;

  dram_cmd_responder_if bus();

  dram_cmd_responder dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .dram   (bus)
  );

  always #5 ACLK = ~ACLK;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: memory map plus absolute-cycle timestamps for when commands become legal.
  logic [31:0] mem   [int];
  bit          known [int];
  int          n;
  bit          row_open;
  int          row;
  int          ready_at;
  bit          rd_pend;
  int          rd_due;
  int          rd_addr;
  logic [31:0] exp_q;
  bit          q_known;
  bit          exp_valid;
  bit          exp_err;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] d,
                                              input logic [3:0] wen);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (wen[i] == 1'b0) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    rd_pend   = 0;
    row_open  = 0;
    ready_at  = 0;
    n         = 0;
    exp_q     = 32'h0;
    q_known   = 1;
    exp_valid = 0;
    exp_err   = 0;
  endtask

  task automatic model_edge(input logic csn, input logic rasn, input logic casn,
                            input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
    int  kind;   // 0 nop 1 pre 2 act 3 rd 4 wr 5 illegal
    bit  ok;
    bit  bad;
    bit  expire;
    int  addr;
    logic [31:0] old_w;
    if (csn || (rasn && casn))        kind = 0;
    else if (!rasn && casn)           kind = (wen == 4'h0) ? 1 : (wen == 4'hF) ? 2 : 5;
    else if (rasn && !casn)           kind = (wen == 4'hF) ? 3 : 4;
    else                              kind = 5;
    expire = rd_pend && (n == rd_due);
    addr   = row * (1 << COL_BITS) + int'(a[COL_BITS-1:0]);
    ok  = 0;
    bad = 0;
    if (kind == 0)           ok = 0;
    else if (kind == 5)      bad = 1;
    else if (rd_pend) begin
`ifdef DRAM_RESP_WRBYPASS_EN
      ok = (kind == 4) && expire;
`endif
      bad = !ok;
    end else if (n < ready_at) bad = 1;
    else begin
      ok  = row_open ? (kind != 2) : (kind == 1 || kind == 2);
      bad = !ok;
    end
    exp_valid = 0;
    if (expire) begin
      exp_valid = 1;
      rd_pend   = 0;
      q_known   = known.exists(rd_addr) && known[rd_addr];
      if (q_known) exp_q = mem[rd_addr];
`ifdef DRAM_RESP_WRBYPASS_EN
      if (ok && kind == 4 && addr == rd_addr) begin
        exp_q   = merge_bytes(exp_q, d, wen);
        q_known = q_known || (wen == 4'h0);
      end
`endif
    end
    if (bad) exp_err = 1;
    if (ok) begin
      case (kind)
        1: begin row_open = 0; ready_at = n + T_RP; end
        2: begin row_open = 1; row = int'(a); ready_at = n + T_RCD; end
        3: begin rd_pend = 1; rd_due = n + T_CL; rd_addr = addr; end
        4: begin
          old_w = mem.exists(addr) ? mem[addr] : 32'h0;
          mem[addr] = merge_bytes(old_w, d, wen);
          if (wen == 4'h0) known[addr] = 1;
        end
        default: ;
      endcase
    end
    n++;
  endtask

  task automatic step(input logic csn, input logic rasn, input logic casn,
                      input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
    bus.CSn  = csn;
    bus.RASn = rasn;
    bus.CASn = casn;
    bus.WEn  = wen;
    bus.A    = a;
    bus.D    = d;
    @(posedge ACLK);
    model_edge(csn, rasn, casn, wen, a, d);
    @(negedge ACLK);
    check_val("valid", 32'(bus.valid), 32'(exp_valid));
    check_val("cmd_err", 32'(bus.cmd_err), 32'(exp_err));
    if (q_known) check_val("q", bus.Q, exp_q);
  endtask

  task automatic nop(input int k);
    repeat (k) step(1'b1, 1'b1, 1'b1, 4'hF, 11'h0, 32'h0);
  endtask
  task automatic act(input logic [10:0] r);
    step(1'b0, 1'b0, 1'b1, 4'hF, r, 32'h0);
  endtask
  task automatic pre();
    step(1'b0, 1'b0, 1'b1, 4'h0, 11'h0, 32'h0);
  endtask
  task automatic rd(input logic [10:0] c);
    step(1'b0, 1'b1, 1'b0, 4'hF, c, 32'h0);
  endtask
  task automatic wr(input logic [10:0] c, input logic [31:0] d, input logic [3:0] wen);
    step(1'b0, 1'b1, 1'b0, wen, c, d);
  endtask

  // Asserted mid low-phase so the reset is seen asynchronously.
  task automatic apply_reset();
    #2 ARESET = 1'b1;
    #1;
    check_val("rst_valid", 32'(bus.valid), 32'h0);
    check_val("rst_err", 32'(bus.cmd_err), 32'h0);
    check_val("rst_q", bus.Q, 32'h0);
    model_reset();
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  function automatic logic [10:0] pick_row(input int idx);
    case (idx)
      0:       return 11'h000;
      1:       return 11'h005;
      2:       return 11'h3FF;
      default: return 11'h7FF;
    endcase
  endfunction

  task automatic random_cmd();
    int r;
    logic [3:0] wen;
    r = $urandom_range(0, 99);
    if (r < 8)
      step(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
           pick_row($urandom_range(0, 3)) | 11'($urandom_range(16, 23)), $urandom);
`ifdef DRAM_RESP_WRBYPASS_EN
    else if (rd_pend && n == rd_due && r < 50)
      wr(11'($urandom_range(16, 23)), $urandom, 4'($urandom_range(0, 14)));
`endif
    else if (rd_pend || n < ready_at) nop(1);
    else if (!row_open) begin
      if (r < 80) act(pick_row($urandom_range(0, 3)));
      else        pre();
    end else begin
      r = $urandom_range(0, 99);
      wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 14));
      if (r < 40)      wr(11'($urandom_range(16, 23)), $urandom, wen);
      else if (r < 75) rd(11'($urandom_range(16, 23)));
      else if (r < 85) pre();
      else             nop(1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    ARESET = 1'b0;
    bus.CSn = 1'b1; bus.RASn = 1'b1; bus.CASn = 1'b1;
    bus.WEn = 4'hF; bus.A = 11'h0; bus.D = 32'h0;
    model_reset();
    @(negedge ACLK);

    // Full write then read: valid exactly at ACT+11
    apply_reset();
    act(11'h005);
    nop(4);
    wr(11'h010, 32'hDEADBEEF, 4'h0);
    rd(11'h010);
    nop(4);
    check_val("t1_no_early_valid", 32'(bus.valid), 32'h0);
    nop(1);
    check_val("t1_valid", 32'(bus.valid), 32'h1);
    check_val("t1_q", bus.Q, 32'hDEADBEEF);
    nop(1);
    check_val("t1_valid_drop", 32'(bus.valid), 32'h0);
    check_val("t1_q_hold", bus.Q, 32'hDEADBEEF);

    // Partial write
    wr(11'h010, 32'h11223344, 4'b1010);
    rd(11'h010);
    nop(5);
    check_val("t2_partial_q", bus.Q, 32'hDE22BE44);

    // tRCD boundary
    apply_reset();
    act(11'h005);
    nop(3);
    rd(11'h010);
    check_val("t3_early_rd_err", 32'(bus.cmd_err), 32'h1);
    rd(11'h010);
    nop(4);
    check_val("t3_no_valid_yet", 32'(bus.valid), 32'h0);
    nop(1);
    check_val("t3_valid", 32'(bus.valid), 32'h1);
    check_val("t3_q", bus.Q, 32'hDE22BE44);

    // tRP boundary and row isolation
    apply_reset();
    pre();
    nop(3);
    act(11'h3FF);
    check_val("t4_early_act_err", 32'(bus.cmd_err), 32'h1);
    act(11'h3FF);
    nop(4);
    wr(11'h010, 32'hCAFEF00D, 4'h0);
    rd(11'h010);
    nop(5);
    check_val("t4_row3ff_q", bus.Q, 32'hCAFEF00D);
    pre();
    nop(4);
    act(11'h005);
    nop(4);
    rd(11'h010);
    nop(5);
    check_val("t4_row5_kept", bus.Q, 32'hDE22BE44);

    // Deselected command and RAS+CAS illegal
    apply_reset();
    act(11'h005);
    nop(4);
    step(1'b1, 1'b1, 1'b0, 4'hF, 11'h010, 32'h0);
    nop(6);
    check_val("t5_cs_no_err", 32'(bus.cmd_err), 32'h0);
    step(1'b0, 1'b0, 1'b0, 4'hF, 11'h010, 32'h0);
    check_val("t5_ill_err", 32'(bus.cmd_err), 32'h1);

    // Async reset inside READ_LAT
    apply_reset();
    act(11'h005);
    nop(4);
    rd(11'h010);
    nop(2);
    apply_reset();
    nop(8);
    check_val("t6_no_valid", 32'(bus.valid), 32'h0);
    rd(11'h010);
    check_val("t6_idle_rd_err", 32'(bus.cmd_err), 32'h1);
    act(11'h005);
    nop(4);
    rd(11'h010);
    nop(5);
    check_val("t6_array_kept", bus.Q, 32'hDE22BE44);

    // Randomized episodes
    for (int ep = 0; ep < 8; ep++) begin
      apply_reset();
      repeat (80) random_cmd();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
